// File: rtl/branch_resolve_queue_pkg.sv
// Shared types for the branch resolve queue: entry layout, entry state
// encoding and the retire packet sent to the gselect predictor.
package branch_resolve_queue_pkg;

    localparam int XLEN                      = 32;
    localparam int BRQ_N                     = 2;
    localparam int BRANCH_PREDICTION_BITS    = 8;
    localparam int BRANCH_PREDICTION_PC_BITS = 8;

    localparam int BRQ_DEPTH = 8;
    localparam int BRQ_TAG_W = $clog2(BRQ_DEPTH);

    typedef logic [BRQ_TAG_W-1:0] BRQ_TAG;

    // Lifecycle of one queue slot.
    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        PENDING  = 2'd1,
        RESOLVED = 2'd2
    } BRQ_STATE;

    typedef struct packed {
        BRQ_STATE                               state;
        logic [BRANCH_PREDICTION_PC_BITS-1:0]   pc_slice;
        logic [BRANCH_PREDICTION_BITS-1:0]      history;
        logic                                   pred_taken;
        logic                                   actual_taken;
    } BRQ_ENTRY;

    // Update packet consumed by the gselect predictor.
    typedef struct packed {
        logic                                   valid;
        logic [BRANCH_PREDICTION_PC_BITS-1:0]   pc;
        logic [BRANCH_PREDICTION_BITS-1:0]      bp_indicies;
        logic                                   taken;
    } BRANCH_PREDICTION_PACKET;

endpackage

// File: rtl/branch_resolve_queue_retire_select.sv
// Picks how many head entries retire this cycle: the longest run of
// RESOLVED entries from head, cut right after the first mispredict.
module brq_retire_select
    import branch_resolve_queue_pkg::*;
#(
    parameter int N   = BRQ_N,
    parameter int K_W = $clog2(N + 1)
) (
    input  BRQ_ENTRY [N-1:0] entries,
    output logic [K_W-1:0]   retire_k,
    output logic [N-1:0]     lane_valid,
    output logic [N-1:0]     lane_mispredict
);

    logic stop;

    // Payload fields are carried alongside but not needed for the decision.
    logic unused_payload;

    // Scan head-ordered entries; a mispredicted entry retires but ends the run.
    always_comb begin
        retire_k        = '0;
        lane_valid      = '0;
        lane_mispredict = '0;
        stop            = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!stop && entries[i].state == RESOLVED) begin
                lane_valid[i] = 1'b1;
                retire_k      = K_W'(i + 1);
                if (entries[i].actual_taken != entries[i].pred_taken) begin
                    lane_mispredict[i] = 1'b1;
                    stop               = 1'b1;
                end
            end else begin
                stop = 1'b1;
            end
        end
    end

    // Fold the untouched payload bits so they are visibly consumed.
    always_comb begin
        unused_payload = 1'b0;
        for (int i = 0; i < N; i++) begin
            unused_payload = unused_payload ^ (^entries[i].pc_slice) ^ (^entries[i].history);
        end
    end

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order tracker for in-flight conditional branches. Entries are allocated
// at dispatch, resolved out of order by execute, and retired in program order
// as predictor update packets; a retiring mispredict flushes younger entries.
module branch_resolve_queue
    import branch_resolve_queue_pkg::*;
#(
    parameter int N     = BRQ_N,
    parameter int DEPTH = BRQ_DEPTH,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic                                           clock,
    input  logic                                           reset,
    input  logic [N-1:0]                                   alloc_valid,
    input  logic [N-1:0][XLEN-1:0]                         alloc_pc,
    input  logic [N-1:0][BRANCH_PREDICTION_BITS-1:0]       alloc_history,
    input  logic [N-1:0]                                   alloc_pred_taken,
    output logic                                           alloc_ready,
    output logic [N-1:0][TAG_W-1:0]                        alloc_tag,
    input  logic [N-1:0]                                   resolve_valid,
    input  logic [N-1:0][TAG_W-1:0]                        resolve_tag,
    input  logic [N-1:0]                                   resolve_taken,
    output BRANCH_PREDICTION_PACKET [N-1:0]                bp_resolve,
    output logic                                           branch_mispredict,
    output logic [TAG_W:0]                                 count
);

    localparam int PC_BITS = BRANCH_PREDICTION_PC_BITS;
    localparam int K_W     = $clog2(N + 1);

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [TAG_W:0] head;
    logic [TAG_W:0] tail;

    BRQ_ENTRY mem [DEPTH];

    logic [K_W-1:0]                n_alloc;
    logic [N-1:0][TAG_W-1:0]       head_idx;
    BRQ_ENTRY [N-1:0]              head_entries;
    logic [K_W-1:0]                retire_k;
    logic [N-1:0]                  retire_valid;
    logic [N-1:0]                  retire_mispredict;
    logic                          mispredict_now;
    BRANCH_PREDICTION_PACKET [N-1:0] pkt_next;
    logic [N-1:0][XLEN-PC_BITS-1:0] unused_pc_bits;

    assign count = tail - head;

    // Frees from this cycle's retire are not forwarded; only current occupancy counts.
    assign alloc_ready = reset && !branch_mispredict &&
                         (count <= (TAG_W+1)'(DEPTH - N));

    // Compact valid lanes: the k-th valid lane gets tail+k.
    always_comb begin
        n_alloc   = '0;
        alloc_tag = '0;
        for (int i = 0; i < N; i++) begin
            alloc_tag[i] = tail[TAG_W-1:0] + TAG_W'(n_alloc);
            if (alloc_valid[i]) n_alloc = n_alloc + K_W'(1);
        end
    end

    // Only the word-aligned PC slice is stored.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            unused_pc_bits[i] = {alloc_pc[i][XLEN-1:PC_BITS+2], alloc_pc[i][1:0]};
        end
    end

    // Present the oldest N slots in program order to the retire selector.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            head_idx[i]     = head[TAG_W-1:0] + TAG_W'(i);
            head_entries[i] = mem[head_idx[i]];
        end
    end

    brq_retire_select #(
        .N   (N),
        .K_W (K_W)
    ) u_retire_select (
        .entries         (head_entries),
        .retire_k        (retire_k),
        .lane_valid      (retire_valid),
        .lane_mispredict (retire_mispredict)
    );

    assign mispredict_now = |retire_mispredict;

    // Build next-cycle predictor packets from the retiring entries.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            pkt_next[i] = '0;
            if (retire_valid[i]) begin
                pkt_next[i].valid       = 1'b1;
                pkt_next[i].pc          = head_entries[i].pc_slice;
                pkt_next[i].bp_indicies = head_entries[i].history;
                pkt_next[i].taken       = head_entries[i].actual_taken;
            end
        end
    end

    // Queue state: retire at head, then either flush on mispredict or
    // apply this cycle's resolutions and allocations.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head              <= '0;
            tail              <= '0;
            bp_resolve        <= '0;
            branch_mispredict <= 1'b0;
            for (int d = 0; d < DEPTH; d++) mem[d] <= '0;
        end else begin
            bp_resolve        <= pkt_next;
            branch_mispredict <= mispredict_now;
            head              <= head + (TAG_W+1)'(retire_k);

            for (int i = 0; i < N; i++) begin
                if (retire_valid[i]) mem[head_idx[i]].state <= EMPTY;
            end

            if (mispredict_now) begin
                // Everything younger than the mispredict is wrong-path work.
                tail <= head + (TAG_W+1)'(retire_k);
                for (int d = 0; d < DEPTH; d++) mem[d].state <= EMPTY;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (resolve_valid[i] && mem[resolve_tag[i]].state == PENDING) begin
                        mem[resolve_tag[i]].state        <= RESOLVED;
                        mem[resolve_tag[i]].actual_taken <= resolve_taken[i];
                    end
                end
                if (alloc_ready) begin
                    for (int i = 0; i < N; i++) begin
                        if (alloc_valid[i]) begin
                            mem[alloc_tag[i]].state        <= PENDING;
                            mem[alloc_tag[i]].pc_slice     <= alloc_pc[i][PC_BITS+1:2];
                            mem[alloc_tag[i]].history      <= alloc_history[i];
                            mem[alloc_tag[i]].pred_taken   <= alloc_pred_taken[i];
                            mem[alloc_tag[i]].actual_taken <= 1'b0;
                        end
                    end
                    tail <= tail + (TAG_W+1)'(n_alloc);
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue: in-order retire, mispredict flush,
// full/wrap behaviour, out-of-order resolution and asynchronous reset.
module tb_branch_resolve_queue;
    import branch_resolve_queue_pkg::*;

    localparam int N     = BRQ_N;
    localparam int TAG_W = BRQ_TAG_W;

    logic                                      clock = 1'b0;
    logic                                      reset = 1'b0;
    logic [N-1:0]                              alloc_valid;
    logic [N-1:0][XLEN-1:0]                    alloc_pc;
    logic [N-1:0][BRANCH_PREDICTION_BITS-1:0]  alloc_history;
    logic [N-1:0]                              alloc_pred_taken;
    logic                                      alloc_ready;
    logic [N-1:0][TAG_W-1:0]                   alloc_tag;
    logic [N-1:0]                              resolve_valid;
    logic [N-1:0][TAG_W-1:0]                   resolve_tag;
    logic [N-1:0]                              resolve_taken;
    BRANCH_PREDICTION_PACKET [N-1:0]           bp_resolve;
    logic                                      branch_mispredict;
    logic [TAG_W:0]                            count;

    int passed = 0;
    int total  = 0;

    branch_resolve_queue dut (
        .clock             (clock),
        .reset             (reset),
        .alloc_valid       (alloc_valid),
        .alloc_pc          (alloc_pc),
        .alloc_history     (alloc_history),
        .alloc_pred_taken  (alloc_pred_taken),
        .alloc_ready       (alloc_ready),
        .alloc_tag         (alloc_tag),
        .resolve_valid     (resolve_valid),
        .resolve_tag       (resolve_tag),
        .resolve_taken     (resolve_taken),
        .bp_resolve        (bp_resolve),
        .branch_mispredict (branch_mispredict),
        .count             (count)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        alloc_valid      = '0;
        alloc_pc         = '0;
        alloc_history    = '0;
        alloc_pred_taken = '0;
        resolve_valid    = '0;
        resolve_tag      = '0;
        resolve_taken    = '0;
    endtask

    task automatic reset_dut();
        idle();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic set_alloc(input int lane, input logic [31:0] pc, input logic [7:0] hist, input logic pred);
        alloc_valid[lane]      = 1'b1;
        alloc_pc[lane]         = pc;
        alloc_history[lane]    = hist;
        alloc_pred_taken[lane] = pred;
    endtask

    task automatic set_resolve(input int lane, input int tag, input logic taken);
        resolve_valid[lane] = 1'b1;
        resolve_tag[lane]   = TAG_W'(tag);
        resolve_taken[lane] = taken;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b0;
        #2;
        total++; if (count !== 4'd0) $display("FAIL reset_count got %0d exp 0", count); else passed++;
        total++; if (alloc_ready !== 1'b0) $display("FAIL reset_ready_low got %b exp 0", alloc_ready); else passed++;
        tick();
        total++; if (bp_resolve !== '0) $display("FAIL reset_bp got %h exp 0", bp_resolve); else passed++;
        total++; if (branch_mispredict !== 1'b0) $display("FAIL reset_mispredict got %b exp 0", branch_mispredict); else passed++;
        reset = 1'b1;
        tick();
        total++; if (alloc_ready !== 1'b1) $display("FAIL reset_ready_rise got %b exp 1", alloc_ready); else passed++;
    endtask

    task automatic test_in_order();
        BRANCH_PREDICTION_PACKET e0, e1;
        reset_dut();
        set_alloc(0, 32'h100, 8'h3, 1'b1);
        set_alloc(1, 32'h104, 8'h5, 1'b0);
        #1;
        total++; if (alloc_tag[0] !== 3'd0) $display("FAIL inord_tag0 got %0d exp 0", alloc_tag[0]); else passed++;
        total++; if (alloc_tag[1] !== 3'd1) $display("FAIL inord_tag1 got %0d exp 1", alloc_tag[1]); else passed++;
        tick(); idle();
        total++; if (count !== 4'd2) $display("FAIL inord_count2 got %0d exp 2", count); else passed++;
        set_resolve(0, 1, 1'b0);
        tick(); idle();
        tick();
        total++; if (bp_resolve[0].valid !== 1'b0) $display("FAIL inord_wait_head got %b exp 0", bp_resolve[0].valid); else passed++;
        set_resolve(0, 0, 1'b1);
        tick(); idle();
        total++; if (bp_resolve[0].valid !== 1'b0) $display("FAIL inord_no_same_cycle got %b exp 0", bp_resolve[0].valid); else passed++;
        tick();
        e0 = '{valid: 1'b1, pc: 8'h40, bp_indicies: 8'h03, taken: 1'b1};
        e1 = '{valid: 1'b1, pc: 8'h41, bp_indicies: 8'h05, taken: 1'b0};
        total++; if (bp_resolve[0] !== e0) $display("FAIL inord_pkt0 got %h exp %h", bp_resolve[0], e0); else passed++;
        total++; if (bp_resolve[1] !== e1) $display("FAIL inord_pkt1 got %h exp %h", bp_resolve[1], e1); else passed++;
        total++; if (branch_mispredict !== 1'b0) $display("FAIL inord_mispredict got %b exp 0", branch_mispredict); else passed++;
        total++; if (count !== 4'd0) $display("FAIL inord_count0 got %0d exp 0", count); else passed++;
        tick();
        total++; if (bp_resolve[0].valid !== 1'b0) $display("FAIL inord_pulse_once got %b exp 0", bp_resolve[0].valid); else passed++;
    endtask

    task automatic test_mispredict();
        BRANCH_PREDICTION_PACKET e0;
        reset_dut();
        set_alloc(0, 32'h200, 8'h1, 1'b1);
        set_alloc(1, 32'h204, 8'h2, 1'b1);
        tick(); idle();
        set_alloc(0, 32'h208, 8'h3, 1'b1);
        #1;
        total++; if (alloc_tag[0] !== 3'd2) $display("FAIL mis_tag2 got %0d exp 2", alloc_tag[0]); else passed++;
        tick(); idle();
        total++; if (count !== 4'd3) $display("FAIL mis_count3 got %0d exp 3", count); else passed++;
        set_resolve(0, 0, 1'b0);
        tick(); idle();
        // decision cycle: these alloc/resolve inputs must be discarded
        set_alloc(0, 32'h20C, 8'h4, 1'b1);
        set_resolve(0, 2, 1'b1);
        #1;
        total++; if (alloc_ready !== 1'b1) $display("FAIL mis_ready_decision got %b exp 1", alloc_ready); else passed++;
        tick(); idle();
        e0 = '{valid: 1'b1, pc: 8'h80, bp_indicies: 8'h01, taken: 1'b0};
        total++; if (bp_resolve[0] !== e0) $display("FAIL mis_pkt0 got %h exp %h", bp_resolve[0], e0); else passed++;
        total++; if (bp_resolve[1].valid !== 1'b0) $display("FAIL mis_pkt1_valid got %b exp 0", bp_resolve[1].valid); else passed++;
        total++; if (branch_mispredict !== 1'b1) $display("FAIL mis_pulse got %b exp 1", branch_mispredict); else passed++;
        total++; if (count !== 4'd0) $display("FAIL mis_flush_count got %0d exp 0", count); else passed++;
        total++; if (alloc_ready !== 1'b0) $display("FAIL mis_ready_pulse got %b exp 0", alloc_ready); else passed++;
        set_alloc(0, 32'h210, 8'h5, 1'b1);
        set_resolve(0, 2, 1'b1);
        tick(); idle();
        total++; if (branch_mispredict !== 1'b0) $display("FAIL mis_pulse_end got %b exp 0", branch_mispredict); else passed++;
        total++; if (count !== 4'd0) $display("FAIL mis_alloc_dropped got %0d exp 0", count); else passed++;
        tick();
        total++; if (bp_resolve[0].valid !== 1'b0) $display("FAIL mis_late_resolve got %b exp 0", bp_resolve[0].valid); else passed++;
    endtask

    task automatic test_full_wrap();
        reset_dut();
        for (int c = 0; c < 4; c++) begin
            set_alloc(0, 32'h300 + 32'(8 * c), 8'(2 * c), 1'b1);
            set_alloc(1, 32'h304 + 32'(8 * c), 8'(2 * c + 1), 1'b1);
            tick(); idle();
        end
        total++; if (count !== 4'd8) $display("FAIL full_count8 got %0d exp 8", count); else passed++;
        total++; if (alloc_ready !== 1'b0) $display("FAIL full_ready got %b exp 0", alloc_ready); else passed++;
        set_alloc(0, 32'h400, 8'h0, 1'b1);
        set_alloc(1, 32'h404, 8'h0, 1'b1);
        #1;
        total++; if (alloc_tag[0] !== 3'd0) $display("FAIL full_tail_wrap got %0d exp 0", alloc_tag[0]); else passed++;
        tick(); idle();
        total++; if (count !== 4'd8) $display("FAIL full_drop got %0d exp 8", count); else passed++;
        set_resolve(0, 0, 1'b1);
        set_resolve(1, 1, 1'b1);
        tick(); idle();
        // retire cycle while full: alloc must not see the frees
        set_alloc(0, 32'h440, 8'h0, 1'b1);
        set_alloc(1, 32'h444, 8'h0, 1'b1);
        tick(); idle();
        total++; if (bp_resolve[0].pc !== 8'hC0) $display("FAIL full_retire_pc0 got %h exp c0", bp_resolve[0].pc); else passed++;
        total++; if (bp_resolve[1].pc !== 8'hC1) $display("FAIL full_retire_pc1 got %h exp c1", bp_resolve[1].pc); else passed++;
        total++; if (count !== 4'd6) $display("FAIL full_no_forward got %0d exp 6", count); else passed++;
        total++; if (alloc_ready !== 1'b1) $display("FAIL full_ready_back got %b exp 1", alloc_ready); else passed++;
        set_alloc(0, 32'h500, 8'h0, 1'b1);
        set_alloc(1, 32'h504, 8'h0, 1'b1);
        #1;
        total++; if (alloc_tag[0] !== 3'd0) $display("FAIL wrap_tag0 got %0d exp 0", alloc_tag[0]); else passed++;
        total++; if (alloc_tag[1] !== 3'd1) $display("FAIL wrap_tag1 got %0d exp 1", alloc_tag[1]); else passed++;
        tick(); idle();
        total++; if (count !== 4'd8) $display("FAIL wrap_count8 got %0d exp 8", count); else passed++;
    endtask

    task automatic test_out_of_order();
        BRANCH_PREDICTION_PACKET e0, e1;
        reset_dut();
        set_alloc(0, 32'h120, 8'h7, 1'b0);
        set_alloc(1, 32'h124, 8'h8, 1'b0);
        tick(); idle();
        set_resolve(0, 1, 1'b0);
        tick(); idle();
        tick();
        total++; if (bp_resolve[1].valid !== 1'b0) $display("FAIL ooo_hold got %b exp 0", bp_resolve[1].valid); else passed++;
        total++; if (count !== 4'd2) $display("FAIL ooo_count2 got %0d exp 2", count); else passed++;
        set_resolve(0, 0, 1'b0);
        tick(); idle();
        tick();
        e0 = '{valid: 1'b1, pc: 8'h48, bp_indicies: 8'h07, taken: 1'b0};
        e1 = '{valid: 1'b1, pc: 8'h49, bp_indicies: 8'h08, taken: 1'b0};
        total++; if (bp_resolve[0] !== e0) $display("FAIL ooo_pkt0 got %h exp %h", bp_resolve[0], e0); else passed++;
        total++; if (bp_resolve[1] !== e1) $display("FAIL ooo_pkt1 got %h exp %h", bp_resolve[1], e1); else passed++;
        // pair where the younger retiring branch mispredicts
        set_alloc(0, 32'h130, 8'h9, 1'b1);
        set_alloc(1, 32'h134, 8'hA, 1'b1);
        tick(); idle();
        set_resolve(0, 3, 1'b0);
        set_resolve(1, 2, 1'b1);
        tick(); idle();
        tick();
        e0 = '{valid: 1'b1, pc: 8'h4C, bp_indicies: 8'h09, taken: 1'b1};
        e1 = '{valid: 1'b1, pc: 8'h4D, bp_indicies: 8'h0A, taken: 1'b0};
        total++; if (bp_resolve[0] !== e0) $display("FAIL ooo_mis_pkt0 got %h exp %h", bp_resolve[0], e0); else passed++;
        total++; if (bp_resolve[1] !== e1) $display("FAIL ooo_mis_pkt1 got %h exp %h", bp_resolve[1], e1); else passed++;
        total++; if (branch_mispredict !== 1'b1) $display("FAIL ooo_mis_flag got %b exp 1", branch_mispredict); else passed++;
    endtask

    task automatic test_async_reset();
        reset_dut();
        set_alloc(0, 32'h600, 8'h1, 1'b1);
        set_alloc(1, 32'h604, 8'h2, 1'b1);
        tick(); idle();
        set_alloc(0, 32'h608, 8'h3, 1'b1);
        set_alloc(1, 32'h60C, 8'h4, 1'b1);
        tick(); idle();
        set_alloc(0, 32'h610, 8'h5, 1'b1);
        tick(); idle();
        total++; if (count !== 4'd5) $display("FAIL areset_count5 got %0d exp 5", count); else passed++;
        set_resolve(0, 0, 1'b1);
        tick(); idle();
        #2;
        reset = 1'b0;
        #1;
        total++; if (count !== 4'd0) $display("FAIL areset_count_now got %0d exp 0", count); else passed++;
        total++; if (alloc_ready !== 1'b0) $display("FAIL areset_ready got %b exp 0", alloc_ready); else passed++;
        tick();
        reset = 1'b1;
        tick();
        total++; if (bp_resolve[0].valid !== 1'b0) $display("FAIL areset_no_pkt got %b exp 0", bp_resolve[0].valid); else passed++;
        total++; if (count !== 4'd0) $display("FAIL areset_count_after got %0d exp 0", count); else passed++;
        set_resolve(0, 0, 1'b1);
        tick(); idle();
        tick();
        total++; if (bp_resolve[0].valid !== 1'b0) $display("FAIL areset_stale_resolve got %b exp 0", bp_resolve[0].valid); else passed++;
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_mispredict();
        test_full_wrap();
        test_out_of_order();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout passed %0d of %0d", passed, total);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
In-order tracker for in-flight conditional branches.
- Allocates one entry per branch at dispatch, holding PC slice, global-history snapshot and predicted direction.
- Accepts out-of-order resolutions from execute.
- Retires resolved branches in program order as BRANCH_PREDICTION_PACKETs to the gselect predictor.
- Raises branch_mispredict and flushes younger entries when a retiring branch's actual direction differs from its prediction.

Parameters:
N, `N (2), dispatch/resolve/retire lanes
DEPTH, 8, queue entries; power of two, >= 2*N
TAG_W, $clog2(DEPTH), entry tag width
BP_BITS, `BRANCH_PREDICTION_BITS, history/index width
PC_BITS, `BRANCH_PREDICTION_PC_BITS, PC slice width

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-low (entire state cleared while 0)
alloc_valid  input  [N]  branch in dispatch lane i; lanes in program order, lane 0 oldest
alloc_pc  input  [N][XLEN]  branch PC
alloc_history  input  [N][BP_BITS]  predictor global_history_out at prediction
alloc_pred_taken  input  [N]  predicted direction
alloc_ready  output  1  free entries >= N and branch_mispredict==0
alloc_tag  output  [N][TAG_W]  tag of the k-th valid alloc lane = tail+k (combinational)
resolve_valid  input  [N]  execute resolution
resolve_tag  input  [N][TAG_W]  entry being resolved
resolve_taken  input  [N]  actual direction
bp_resolve  output  BRANCH_PREDICTION_PACKET[N]  registered retire packets to predictor
branch_mispredict  output  1  registered; one-cycle pulse
count  output  [TAG_W:0]  occupied entries

Behaviour:
- Circular buffer. head/tail are TAG_W+1 bits including a wrap bit.
  - empty: head==tail.
  - full: pointer bits equal and wrap bits differ.
  - count = tail-head, modulo 2^(TAG_W+1).
- Per-entry state: EMPTY -> PENDING (alloc) -> RESOLVED (resolve) -> EMPTY (retire or flush).
- Allocation:
  - Only when alloc_ready==1. alloc_valid while alloc_ready==0 is dropped, with no state change.
  - Valid lanes are compacted: k valid lanes take tail..tail+k-1, and tail advances by k.
  - Stored fields: pc slice alloc_pc[PC_BITS+1:2], history, pred_taken.
- Resolution:
  - Moves a PENDING entry to RESOLVED and stores actual taken.
  - Resolve to an EMPTY or RESOLVED entry is ignored.
  - Distinct lanes never target the same tag.
  - Takes effect at the next edge and is therefore never retired in the same cycle it arrives.
- Retire, evaluated each cycle on registered state:
  - Take the longest run, up to N, of consecutive RESOLVED entries from head.
  - Scanning stops after the first mispredicted entry (actual != pred_taken); that entry is included.
  - Emit on bp_resolve lanes 0..k-1 at the next edge with valid=1, pc=stored slice, bp_indicies=stored history, taken=actual. Remaining lanes have valid=0.
  - head advances by k, so latency is 1 cycle from the entry reaching RESOLVED at head.
- Mispredict:
  - If the run ended on a mispredict, branch_mispredict=1 in the same cycle as its packet. That packet is the highest valid lane, which is what the predictor uses to form corrected history.
  - At that same edge tail <- new head, all younger entries go EMPTY, and alloc/resolve inputs of that cycle are discarded.
  - alloc_ready=0 while branch_mispredict=1.
- Simultaneous alloc and retire with a full queue:
  - Frees are not forwarded; alloc_ready uses current count.
  - Pointer update is tail+=k_alloc, head+=k_retire.
- Reset (reset==0, async):
  - head=tail=0, all entries EMPTY.
  - bp_resolve all fields 0, branch_mispredict=0, count=0.
  - alloc_ready rises after reset release.
  - Mid-operation reset discards all entries without emitting packets.

Decomposition:
- Shared package contents:
  - BRQ_DEPTH, BRQ_TAG_W
  - typedef BRQ_TAG
  - enum BRQ_STATE {EMPTY, PENDING, RESOLVED}
  - struct BRQ_ENTRY {state, pc_slice, history, pred_taken, actual_taken}
  - existing BRANCH_PREDICTION_PACKET reused unchanged
- Sub-module brq_retire_select:
  - Combinational.
  - Inputs: N head-ordered entries.
  - Outputs: retire count k, per-lane valid and mispredict flag.
- Top level holds storage, pointers and output registers.

Test Plan:
- Reset, then alloc pc 0x100 (hist 0x3, pred T) and 0x104 (pred N) → tags 0,1, count=2. Resolve tag1 N then tag0 T → one cycle after the later resolve, bp_resolve[0]={1,0x40,0x3,1}, [1]={1,0x41,..,0}, branch_mispredict=0, count=0.
- Alloc 3 branches with tags 0,1,2, all pred T. Resolve tag0 N → next edge: single packet taken=0, branch_mispredict=1, count=0. Late resolve tag2 ignored, no packet.
- Fill 8 entries → alloc_ready=0, alloc while full dropped, tail unchanged. Retire 2 → alloc_ready=1. Next allocations wrap to tags 0,1.
- Resolve tag1 before tag0 → no packet until tag0 resolves; then both retire together in order.
- Alloc in the mispredict-decision cycle → discarded, count=0 afterwards. During the branch_mispredict pulse alloc_ready=0.
- Assert reset low asynchronously with 5 entries PENDING → outputs 0 immediately; after release count=0, no packets.
